l2_miss_arbiter: RTL and testbench
==================================

# l2_miss_arbiter

Two-requester arbiter and sequencer for the single next-level (L2) memory port shared by the instruction cache and the data cache. Each L1 raises a miss or write-back request carrying a 26-bit line address. The arbiter grants the port round-robin, issues one transaction at a time, waits for L2 completion with a retry timeout, and acknowledges the winning requester. It also keeps per-requester grant and timeout statistics for the statistics module.

## Interface
Parameters:
- ADDR_W, 26, line address width (address[31:6])
- MAX_WAIT, 255, cycles in WAIT without l2_ready before a timeout/reissue (1..255)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- d_req  in  1  data cache request, held until d_ack
- d_we  in  1  data request is a write-back (1) or line fill (0)
- d_add  in  ADDR_W  data request line address, stable while d_req
- d_ack  out  1  one-cycle completion pulse to data cache
- i_req  in  1  instruction cache fill request, held until i_ack
- i_add  in  ADDR_W  instruction fill line address, stable while i_req
- i_ack  out  1  one-cycle completion pulse to instruction cache
- l2_req  out  1  one-cycle transaction issue strobe
- l2_we  out  1  write-back flag for issued transaction
- l2_add  out  ADDR_W  issued line address
- l2_ready  in  1  L2 completion, sampled only in WAIT
- busy  out  1  state != IDLE
- timeout  out  1  one-cycle pulse on each timeout
- d_grants, i_grants  out  32  completed transactions per requester
- timeouts  out  32  total timeouts

## Operation
- States: IDLE, ISSUE, WAIT, ACK. Registers: state, owner (0 = data, 1 = instr), last_owner, latched add/we, wait counter (8 bit).
- IDLE: if exactly one req is high, that requester wins. If both are high, the requester that is not last_owner wins. The winner's address and we are latched (i_req always latches we = 0). Go to ISSUE. If no req is high, stay in IDLE.
- ISSUE: l2_req = 1 with the latched address and we. Clear the wait counter. Go to WAIT.
- WAIT:
  - If l2_ready = 1, go to ACK.
  - Otherwise increment the counter. When the counter reaches MAX_WAIT, pulse timeout, increment timeouts, and go to ISSUE to reissue the same transaction. The owner does not change.
- ACK: pulse the owner's ack, increment that owner's grant counter, set last_owner = owner, and go to IDLE.
- Requester rule: req must be low in the cycle after its ack. In that cycle the arbiter is in IDLE and treats a high req as a new request.
- A req that rises while another transaction is in flight waits in IDLE arbitration. It is never dropped.
- l2_add and l2_we are held from ISSUE through WAIT. Both are 0 in IDLE and ACK.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0 silently.
- Reset values: state IDLE, last_owner = instr (so data wins the first tie), all outputs 0, all counters 0.
- Reset mid-transaction aborts it with no ack and no counter update. The requester must re-request.

## Timing
- All outputs are registered and driven from state, so no input reaches an output combinationally.
- Minimum latency, with req high in cycle 0 (IDLE) and l2_ready high in cycle 2:
  - cycle 1: l2_req
  - cycle 2: WAIT
  - cycle 3: ack
- Earliest next grant: IDLE in cycle 4, l2_req in cycle 5.
- l2_ready in the ISSUE cycle is ignored. L2 must hold or re-assert it in WAIT.
- On timeout, l2_req reasserts exactly MAX_WAIT+2 cycles after the previous l2_req.
- With both requesters continuously active, grants alternate strictly d, i, d, i.

## Test plan
- Reset, then d_req=1, d_add=0x0ABCDEF, d_we=1, l2_ready high in the first WAIT cycle -> l2_req at cycle 1 with l2_add=0x0ABCDEF and l2_we=1; d_ack at cycle 3; d_grants=1.
- d_req and i_req both high from cycle 0 and held, with 2-cycle L2 latency -> grant order d, i, d, i; each ack arrives once; i_add is issued with l2_we=0.
- MAX_WAIT=4, l2_ready never asserted for i_req -> timeout pulses every 6 cycles; l2_req reissues the same address; timeouts increments; no i_ack. Asserting l2_ready then gives i_ack after 1 cycle.
- i_req rises during a d transaction's WAIT -> i is granted in the IDLE cycle after d_ack; l2_add switches only at i's ISSUE.
- Assert reset while in WAIT -> the next cycle shows IDLE, busy=0, and all outputs and counters 0; the first tie after reset goes to data.
- Preload d_grants near wrap (drive 0xFFFFFFFF transactions, or force in sim), then one more d grant -> d_grants=0 with no side effects.

Source files
------------

// File: rtl/l2_miss_arbiter.sv
// Round-robin arbiter/sequencer sharing the L2 port between the I- and D-caches,
// with timeout-driven reissue and per-requester completion statistics.
module l2_miss_arbiter #(
    parameter int unsigned ADDR_W   = 26,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_add,
    output logic              d_ack,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_add,
    output logic              i_ack,
    output logic              l2_req,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_add,
    input  logic              l2_ready,
    output logic              busy,
    output logic              timeout,
    output logic [31:0]       d_grants,
    output logic [31:0]       i_grants,
    output logic [31:0]       timeouts
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state;
    logic       owner;       // 0 = data, 1 = instr
    logic       last_owner;
    logic [7:0] wait_cnt;

    logic any_req;
    logic pick_i;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        any_req = d_req | i_req;
        pick_i  = (d_req && i_req) ? ~last_owner : ~d_req;
    end

    // l2_add/l2_we double as the latched transaction, so a reissue reuses them as-is.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            wait_cnt   <= '0;
            d_ack      <= 1'b0;
            i_ack      <= 1'b0;
            l2_req     <= 1'b0;
            l2_we      <= 1'b0;
            l2_add     <= '0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            d_grants   <= '0;
            i_grants   <= '0;
            timeouts   <= '0;
        end else begin
            l2_req  <= 1'b0;
            timeout <= 1'b0;
            d_ack   <= 1'b0;
            i_ack   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner  <= pick_i;
                        l2_add <= pick_i ? i_add : d_add;
                        l2_we  <= ~pick_i & d_we;
                        l2_req <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (l2_ready) begin
                        l2_add     <= '0;
                        l2_we      <= 1'b0;
                        last_owner <= owner;
                        if (owner) begin
                            i_ack    <= 1'b1;
                            i_grants <= i_grants + 32'd1;
                        end else begin
                            d_ack    <= 1'b1;
                            d_grants <= d_grants + 32'd1;
                        end
                        state <= ACK;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        l2_req   <= 1'b1;
                        timeout  <= 1'b1;
                        timeouts <= timeouts + 32'd1;
                        state    <= ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_miss_arbiter.sv
// Directed bench for l2_miss_arbiter: requester/L2 agents, a transaction-level
// reference model checked every cycle, and literal checks pinning key timings.
module tb_l2_miss_arbiter;

    localparam int unsigned AW = 26;
    localparam int unsigned MW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_add = '0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_add = '0;
    logic          l2_ready = 1'b0;
    logic          d_ack, i_ack, l2_req, l2_we, busy, timeout;
    logic [AW-1:0] l2_add;
    logic [31:0]   d_grants, i_grants, timeouts;

    l2_miss_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_we(d_we), .d_add(d_add), .d_ack(d_ack),
        .i_req(i_req), .i_add(i_add), .i_ack(i_ack),
        .l2_req(l2_req), .l2_we(l2_we), .l2_add(l2_add), .l2_ready(l2_ready),
        .busy(busy), .timeout(timeout),
        .d_grants(d_grants), .i_grants(i_grants), .timeouts(timeouts)
    );

    initial forever #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    bit          chk_en = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic expired(input string nm);
        total = total + 1;
        bad = bad + 1;
        $display("FAIL %s actual=no_event required=event cycle=%0d", nm, cyc);
    endtask

    // ---------------- requester and L2 agents ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic          we;
    } dreq_t;
    dreq_t         dq[$];
    logic [AW-1:0] iq[$];
    bit            l2_auto = 1;
    int unsigned   l2_lat = 1;

    initial begin
        bit saw;
        dreq_t tmp;
        forever begin
            @(negedge clk);
            saw = (d_ack === 1'b1);
            @(posedge clk);
            #1;
            if (saw) begin
                d_req = 1'b0;
                tmp = dq.pop_front();
            end else if (!d_req && dq.size() != 0) begin
                d_req = 1'b1;
                d_add = dq[0].a;
                d_we  = dq[0].we;
            end
        end
    end

    initial begin
        bit saw;
        logic [AW-1:0] tmp;
        forever begin
            @(negedge clk);
            saw = (i_ack === 1'b1);
            @(posedge clk);
            #1;
            if (saw) begin
                i_req = 1'b0;
                tmp = iq.pop_front();
            end else if (!i_req && iq.size() != 0) begin
                i_req = 1'b1;
                i_add = iq[0];
            end
        end
    end

    initial begin
        int unsigned left;
        left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (l2_auto) begin
                if (l2_req === 1'b1) begin
                    left = l2_lat;
                    l2_ready = 1'b0;
                end else if (left > 0) begin
                    left = left - 1;
                    l2_ready = (left == 0);
                end else begin
                    l2_ready = 1'b0;
                end
            end else begin
                left = 0;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    // m_age counts cycles since the most recent issue strobe of the open transaction.
    bit            m_infl = 0, m_ack = 0, m_reis = 0, m_owner = 0, m_last = 1;
    int unsigned   m_age = 0;
    logic [AW-1:0] m_addr = '0;
    bit            m_we = 0;
    logic [31:0]   m_dg = '0, m_ig = '0, m_to = '0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("l2_req",   32'(l2_req),   32'(m_infl && m_age == 0));
            chk("l2_add",   32'(l2_add),   m_infl ? 32'(m_addr) : 32'd0);
            chk("l2_we",    32'(l2_we),    32'(m_infl && m_we));
            chk("busy",     32'(busy),     32'(m_infl || m_ack));
            chk("timeout",  32'(timeout),  32'(m_infl && m_age == 0 && m_reis));
            chk("d_ack",    32'(d_ack),    32'(m_ack && !m_owner));
            chk("i_ack",    32'(i_ack),    32'(m_ack && m_owner));
            chk("d_grants", d_grants, m_dg);
            chk("i_grants", i_grants, m_ig);
            chk("timeouts", timeouts, m_to);
        end
        if (reset) begin
            m_infl = 0; m_ack = 0; m_reis = 0; m_last = 1; m_age = 0;
            m_dg = '0; m_ig = '0; m_to = '0;
        end else if (m_ack) begin
            m_ack = 0;
        end else if (m_infl) begin
            if (m_age >= 1 && l2_ready) begin
                m_infl = 0;
                m_ack  = 1;
                if (m_owner) m_ig = m_ig + 1;
                else         m_dg = m_dg + 1;
                m_last = m_owner;
            end else if (m_age == MW + 1) begin
                m_age  = 0;
                m_reis = 1;
                m_to   = m_to + 1;
            end else begin
                m_age  = m_age + 1;
                m_reis = 0;
            end
        end else if (d_req || i_req) begin
            m_owner = (d_req && i_req) ? !m_last : !d_req;
            m_addr  = m_owner ? i_add : d_add;
            m_we    = m_owner ? 1'b0 : d_we;
            m_infl  = 1;
            m_age   = 0;
            m_reis  = 0;
        end
    end

    // ---------------- grant order monitor ----------------
    bit order[$];
    initial forever begin
        @(negedge clk);
        if (d_ack === 1'b1) order.push_back(1'b0);
        if (i_ack === 1'b1) order.push_back(1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic push_d(input logic [AW-1:0] a, input logic we);
        dreq_t r;
        r.a = a;
        r.we = we;
        dq.push_back(r);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while ((busy !== 1'b0 || d_req || i_req || dq.size() != 0 || iq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) expired(nm);
    endtask

    task automatic wait_l2_req(input string nm, input int budget, output int unsigned at);
        int n = 0;
        while (l2_req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (l2_req !== 1'b1) expired(nm);
        at = cyc;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int unsigned t0, ta, ti, ig0, to0;
        logic [3:0] code;

        reset = 1'b1;
        step(2);
        chk_en = 1;
        step(1);

        // single data write-back, L2 ready in the first WAIT cycle
        l2_lat = 1;
        push_d(26'h0ABCDEF, 1'b1);
        step();
        reset = 1'b0;                       // cycle 0: IDLE with d_req high
        step();
        chk("t1_l2_req", 32'(l2_req), 32'd1);
        chk("t1_l2_add", 32'(l2_add), 32'h00ABCDEF);
        chk("t1_l2_we",  32'(l2_we),  32'd1);
        step();
        chk("t1_busy_wait", 32'(busy), 32'd1);
        step();
        chk("t1_d_ack", 32'(d_ack), 32'd1);
        chk("t1_d_grants", d_grants, 32'd1);
        step();
        chk("t1_idle", 32'(busy), 32'd0);
        wait_idle("t1_idle_wait", 20);

        // instruction fill with L2 silent: periodic timeout and reissue
        l2_auto = 0;
        l2_ready = 1'b0;
        iq.push_back(26'h1234567);
        wait_l2_req("to_first_issue", 20, t0);
        step(MW + 2);
        chk("to_reissue1", 32'(l2_req), 32'd1);
        chk("to_pulse1", 32'(timeout), 32'd1);
        chk("to_addr1", 32'(l2_add), 32'h01234567);
        l2_ready = 1'b1;                    // in ISSUE: must be ignored
        step();
        l2_ready = 1'b0;
        step(MW + 1);
        chk("to_reissue2", 32'(l2_req), 32'd1);
        chk("to_count", timeouts, 32'd2);
        chk("to_no_ack", i_grants, 32'd0);
        step(2);
        l2_ready = 1'b1;
        step();
        l2_ready = 1'b0;
        chk("to_i_ack", 32'(i_ack), 32'd1);
        l2_auto = 1;
        wait_idle("to_idle_wait", 20);

        // both requesters continuously active: strict alternation starting with data
        l2_lat = 2;
        order.delete();
        push_d(26'h0000001, 1'b0);
        push_d(26'h3FFFFFF, 1'b1);
        iq.push_back(26'h2AAAAAA);
        iq.push_back(26'h1555555);
        wait_idle("alt_idle_wait", 100);
        chk("alt_count", 32'(order.size()), 32'd4);
        code = '0;
        for (int k = 0; k < 4 && k < order.size(); k++) code[3-k] = order[k];
        chk("alt_order", 32'(code), 32'b0101);

        // instruction request arrives during a data transaction's WAIT
        l2_lat = 3;
        push_d(26'h0F0F0F0, 1'b0);
        wait_l2_req("cc_d_issue", 20, t0);
        step();
        iq.push_back(26'h00FF00F);
        begin
            int n = 0;
            while (d_ack !== 1'b1 && n < 20) begin step(); n++; end
            if (d_ack !== 1'b1) expired("cc_d_ack");
            ta = cyc;
        end
        wait_l2_req("cc_i_issue", 20, ti);
        chk("cc_i_latency", ti - ta, 32'd2);
        chk("cc_i_addr", 32'(l2_add), 32'h000FF00F);
        wait_idle("cc_idle_wait", 40);

        // reset during WAIT; last owner before reset is data
        l2_lat = 1;
        push_d(26'h0000ABC, 1'b1);
        wait_idle("rs_pre_idle", 20);
        l2_auto = 0;
        l2_ready = 1'b0;
        iq.push_back(26'h0C0FFEE);
        wait_l2_req("rs_i_issue", 20, t0);
        step(2);
        push_d(26'h0DEAD00, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_l2_add", 32'(l2_add), 32'd0);
        chk("rs_d_grants", d_grants, 32'd0);
        chk("rs_i_grants", i_grants, 32'd0);
        chk("rs_timeouts", timeouts, 32'd0);
        l2_auto = 1;
        step();
        chk("rs_tie_data", 32'(l2_add), 32'h00DEAD00);
        chk("rs_tie_we", 32'(l2_we), 32'd1);
        wait_idle("rs_idle_wait", 40);

        // data grant counter wraps silently
        force dut.d_grants = 32'hFFFF_FFFF;
        release dut.d_grants;
        m_dg = 32'hFFFF_FFFF;
        ig0 = i_grants;
        to0 = timeouts;
        push_d(26'h0000040, 1'b0);
        wait_idle("wr_idle_wait", 20);
        chk("wr_d_grants", d_grants, 32'd0);
        chk("wr_i_grants", i_grants, ig0);
        chk("wr_timeouts", timeouts, to0);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
